// File: rtl/command_processor_pkg.sv
// Shared definitions for the command processor: frame opcodes, FSM states and
// the default error byte.
package command_processor_pkg;

  localparam logic [7:0] OP_WRITE       = 8'hAA;
  localparam logic [7:0] OP_READ        = 8'hBB;
  localparam logic [7:0] OP_WRITE_ALU   = 8'hCC;
  localparam logic [7:0] OP_ALU         = 8'hDD;
  localparam logic [7:0] OP_BURST_WRITE = 8'hEE;
  localparam logic [7:0] OP_BURST_READ  = 8'hEF;

  localparam logic [7:0] DEFAULT_ERROR_CODE = 8'hFF;

  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    GET_COUNT,
    GET_DATA,
    GET_A,
    GET_B,
    GET_FUNC,
    WRITE_A,
    WRITE_B,
    RF_READ,
    RF_WAIT,
    ALU_START,
    ALU_WAIT,
    PUSH_LO,
    PUSH_HI,
    PUSH_ERR
  } state_e;

  function automatic logic is_get_state(input state_e s);
    return s inside {GET_ADDR, GET_COUNT, GET_DATA, GET_A, GET_B, GET_FUNC};
  endfunction

endpackage

// File: rtl/command_processor_response_fifo.sv
// Synchronous response queue; full/empty come from pointers carrying one extra
// wrap bit. The head is read straight out of the storage flops.
module response_fifo #(
  parameter int DATA_WIDTH          = 8,
  parameter int RESPONSE_FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  full,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  localparam int PW = $clog2(RESPONSE_FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [RESPONSE_FIFO_DEPTH];
  logic [PW:0]           wr_ptr_q, wr_ptr_d;
  logic [PW:0]           rd_ptr_q, rd_ptr_d;
  logic                  empty;
  logic                  pop;
  logic                  do_push;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];
  assign pop       = !empty && out_ready;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign do_push   = push && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/command_processor.sv
// Frame parser driving register-file and ALU accesses, with an inter-byte
// timeout and a response queue toward the UART transmitter.
module command_processor
  import command_processor_pkg::*;
#(
  parameter int                    DATA_WIDTH          = 8,
  parameter int                    REGISTER_FILE_DEPTH = 16,
  parameter int                    RESPONSE_FIFO_DEPTH = 8,
  parameter int                    TIMEOUT_CYCLES      = 4096,
  parameter logic [DATA_WIDTH-1:0] ERROR_CODE          = DATA_WIDTH'(DEFAULT_ERROR_CODE)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   receiver_parallel_data_valid_synchronized,
  input  logic [DATA_WIDTH-1:0]                  receiver_parallel_data_synchronized,
  output logic [$clog2(REGISTER_FILE_DEPTH)-1:0] register_file_address,
  output logic                                   register_file_write_enable,
  output logic [DATA_WIDTH-1:0]                  register_file_write_data,
  output logic                                   register_file_read_enable,
  input  logic                                   register_file_read_data_valid,
  input  logic [DATA_WIDTH-1:0]                  register_file_read_data,
  output logic [3:0]                             ALU_function,
  output logic                                   ALU_enable,
  output logic                                   ALU_clk_enable,
  input  logic                                   ALU_result_valid,
  input  logic [2*DATA_WIDTH-1:0]                ALU_result,
  output logic                                   transmitter_parallel_data_valid,
  output logic [DATA_WIDTH-1:0]                  transmitter_parallel_data,
  input  logic                                   transmitter_ready,
  output logic                                   receiver_overrun
);

  localparam int AW = $clog2(REGISTER_FILE_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic                    rx_valid;
  logic [DATA_WIDTH-1:0]   rx;
  assign rx_valid = receiver_parallel_data_valid_synchronized;
  assign rx       = receiver_parallel_data_synchronized;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   op_q, op_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [3:0]              func_q, func_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;
  logic                    wr_pend_q, wr_pend_d;
  logic [AW-1:0]           wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    overrun_q, overrun_d;

  logic                    in_get;
  logic                    push;
  logic [DATA_WIDTH-1:0]   push_data;
  logic                    fifo_full;
  logic                    push_ok;
  logic [AW-1:0]           addr_inc;

  assign push_ok  = !fifo_full || transmitter_ready;
  assign addr_inc = (addr_q == AW'(REGISTER_FILE_DEPTH - 1)) ? '0 : addr_q + AW'(1);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    func_d    = func_q;
    res_d     = res_q;
    wr_pend_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    tmo_d     = '0;
    push      = 1'b0;
    push_data = ERROR_CODE;
    in_get    = is_get_state(state_q);
    overrun_d = rx_valid && !(in_get || state_q == IDLE);
    if (in_get && !rx_valid) tmo_d = tmo_q + TW'(1);

    case (state_q)
      IDLE: if (rx_valid) begin
        op_d = rx;
        case (rx)
          DATA_WIDTH'(OP_WRITE), DATA_WIDTH'(OP_READ),
          DATA_WIDTH'(OP_BURST_WRITE), DATA_WIDTH'(OP_BURST_READ): state_d = GET_ADDR;
          DATA_WIDTH'(OP_WRITE_ALU): state_d = GET_A;
          DATA_WIDTH'(OP_ALU):       state_d = GET_FUNC;
          default: begin
            // Unknown opcode: answer in place, detour only if the queue is blocked.
            if (push_ok) push = 1'b1;
            else         state_d = PUSH_ERR;
          end
        endcase
      end
      GET_ADDR: if (rx_valid) begin
        addr_d = rx[AW-1:0];
        cnt_d  = DATA_WIDTH'(1);
        if (op_q == DATA_WIDTH'(OP_WRITE))     state_d = GET_DATA;
        else if (op_q == DATA_WIDTH'(OP_READ)) state_d = RF_READ;
        else                                   state_d = GET_COUNT;
      end
      GET_COUNT: if (rx_valid) begin
        cnt_d = rx;
        if (rx == '0)                                state_d = IDLE;
        else if (op_q == DATA_WIDTH'(OP_BURST_WRITE)) state_d = GET_DATA;
        else                                         state_d = RF_READ;
      end
      GET_DATA: if (rx_valid) begin
        wr_pend_d = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = rx;
        addr_d    = addr_inc;
        cnt_d     = cnt_q - DATA_WIDTH'(1);
        if (cnt_q == DATA_WIDTH'(1)) state_d = IDLE;
      end
      GET_A: if (rx_valid) begin
        a_d     = rx;
        state_d = GET_B;
      end
      GET_B: if (rx_valid) begin
        b_d     = rx;
        state_d = GET_FUNC;
      end
      GET_FUNC: if (rx_valid) begin
        func_d  = rx[3:0];
        state_d = (op_q == DATA_WIDTH'(OP_WRITE_ALU)) ? WRITE_A : ALU_START;
      end
      WRITE_A:   state_d = WRITE_B;
      WRITE_B:   state_d = ALU_START;
      ALU_START: state_d = ALU_WAIT;
      ALU_WAIT: if (ALU_result_valid) begin
        res_d = ALU_result;
        if (push_ok) begin
          push      = 1'b1;
          push_data = ALU_result[DATA_WIDTH-1:0];
          state_d   = PUSH_HI;
        end else begin
          state_d = PUSH_LO;
        end
      end
      PUSH_LO: if (push_ok) begin
        push      = 1'b1;
        push_data = res_q[DATA_WIDTH-1:0];
        state_d   = PUSH_HI;
      end
      PUSH_HI: if (push_ok) begin
        push      = 1'b1;
        push_data = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
        state_d   = IDLE;
      end
      // A read is only issued with a free slot, so the data strobe can always be pushed.
      RF_READ: if (!fifo_full) state_d = RF_WAIT;
      RF_WAIT: if (register_file_read_data_valid) begin
        push      = 1'b1;
        push_data = register_file_read_data;
        addr_d    = addr_inc;
        cnt_d     = cnt_q - DATA_WIDTH'(1);
        state_d   = (cnt_q == DATA_WIDTH'(1)) ? IDLE : RF_READ;
      end
      PUSH_ERR: if (push_ok) begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (in_get && !rx_valid && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = PUSH_ERR;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      func_q    <= '0;
      res_q     <= '0;
      wr_pend_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      tmo_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      func_q    <= func_d;
      res_q     <= res_d;
      wr_pend_q <= wr_pend_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      tmo_q     <= tmo_d;
      overrun_q <= overrun_d;
    end
  end

  // WRITE_A/WRITE_B load the ALU operands into reg0/reg1; other writes come from GET_DATA.
  assign register_file_write_enable = wr_pend_q || state_q == WRITE_A || state_q == WRITE_B;
  assign register_file_address      = (state_q == WRITE_A) ? AW'(0) :
                                      (state_q == WRITE_B) ? AW'(1) :
                                      wr_pend_q            ? wr_addr_q : addr_q;
  assign register_file_write_data   = (state_q == WRITE_A) ? a_q :
                                      (state_q == WRITE_B) ? b_q : wr_data_q;
  assign register_file_read_enable  = (state_q == RF_READ) && !fifo_full;
  assign ALU_function               = func_q;
  assign ALU_enable                 = (state_q == ALU_START);
  assign ALU_clk_enable             = (state_q == ALU_START) || (state_q == ALU_WAIT);
  assign receiver_overrun           = overrun_q;

  response_fifo #(
    .DATA_WIDTH          (DATA_WIDTH),
    .RESPONSE_FIFO_DEPTH (RESPONSE_FIFO_DEPTH)
  ) u_response_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .full      (fifo_full),
    .out_valid (transmitter_parallel_data_valid),
    .out_data  (transmitter_parallel_data),
    .out_ready (transmitter_ready)
  );

endmodule

// File: tb/tb_command_processor.sv
// Directed bench for command_processor: frame vector table plus hand-written
// timing, timeout, back-pressure and reset sequences.
module tb_command_processor;

  localparam int T_CYC = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [3:0]  rf_addr;
  logic        rf_we;
  logic [7:0]  rf_wdata;
  logic        rf_re;
  logic        rf_rvalid;
  logic [7:0]  rf_rdata;
  logic [3:0]  alu_func;
  logic        alu_en;
  logic        alu_clk_en;
  logic        alu_valid;
  logic [15:0] alu_res;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic        overrun;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int ov_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] rf_mem [16];

  command_processor dut (
    .clk                                       (clk),
    .reset                                     (reset),
    .receiver_parallel_data_valid_synchronized (rx_valid),
    .receiver_parallel_data_synchronized       (rx_data),
    .register_file_address                     (rf_addr),
    .register_file_write_enable                (rf_we),
    .register_file_write_data                  (rf_wdata),
    .register_file_read_enable                 (rf_re),
    .register_file_read_data_valid             (rf_rvalid),
    .register_file_read_data                   (rf_rdata),
    .ALU_function                              (alu_func),
    .ALU_enable                                (alu_en),
    .ALU_clk_enable                            (alu_clk_en),
    .ALU_result_valid                          (alu_valid),
    .ALU_result                                (alu_res),
    .transmitter_parallel_data_valid           (tx_valid),
    .transmitter_parallel_data                 (tx_data),
    .transmitter_ready                         (tx_ready),
    .receiver_overrun                          (overrun)
  );

  // Clock
  always #5 clk = ~clk;

  // Register-file model: read data returns one cycle after the strobe.
  always @(posedge clk) begin
    rf_rvalid <= 1'b0;
    if (reset) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= 8'h50 + 8'(i);
      rf_rdata <= '0;
    end else begin
      if (rf_we) rf_mem[rf_addr] <= rf_wdata;
      if (rf_re) begin
        rf_rvalid <= 1'b1;
        rf_rdata  <= rf_mem[rf_addr];
      end
    end
  end

  // ALU model: 0 add, 1 sub, 2 mul on reg0/reg1, result 3 cycles after start.
  int alu_wait = 0;
  always @(posedge clk) begin
    alu_valid <= 1'b0;
    if (reset) begin
      alu_wait <= 0;
      alu_res  <= '0;
    end else if (alu_en) begin
      alu_wait <= 3;
      case (alu_func)
        4'd0:    alu_res <= 16'(rf_mem[0]) + 16'(rf_mem[1]);
        4'd1:    alu_res <= 16'(rf_mem[0]) - 16'(rf_mem[1]);
        4'd2:    alu_res <= 16'(rf_mem[0]) * 16'(rf_mem[1]);
        default: alu_res <= '0;
      endcase
    end else if (alu_wait > 0) begin
      alu_wait <= alu_wait - 1;
      if (alu_wait == 1) alu_valid <= 1'b1;
    end
  end

  // Transmit-side monitor and strobe counters
  always @(posedge clk) begin
    if (!reset) begin
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (rf_re) rd_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_resp(input string name);
    int n = 0;
    logic [7:0] e;
    logic [31:0] a;
    while (got_q.size() < exp_q.size() && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = (got_q.size() > 0) ? 32'(got_q.pop_front()) : 32'hDEAD;
      check($sformatf("%s_byte%0d", name, i), a, 32'(e));
    end
    got_q.delete();
  endtask

  typedef struct {
    string      name;
    int         n_in;
    logic [7:0] in_b [6];
    int         n_exp;
    logic [7:0] exp_b [4];
  } vec_t;

  vec_t vecs [13];

  task automatic set_vec(input int i, input string nm, input int ni,
                         input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                         input int ne, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
    vecs[i].name  = nm;
    vecs[i].n_in  = ni;
    vecs[i].in_b[0] = b0; vecs[i].in_b[1] = b1; vecs[i].in_b[2] = b2;
    vecs[i].in_b[3] = b3; vecs[i].in_b[4] = b4; vecs[i].in_b[5] = b5;
    vecs[i].n_exp = ne;
    vecs[i].exp_b[0] = e0; vecs[i].exp_b[1] = e1;
    vecs[i].exp_b[2] = e2; vecs[i].exp_b[3] = e3;
  endtask

  int lat;

  initial begin
    set_vec(0,  "wr3",          3, 8'hAA, 8'h03, 8'h5A, 0, 0, 0,          0, 0, 0, 0, 0);
    set_vec(1,  "rd3",          2, 8'hBB, 8'h03, 0, 0, 0, 0,              1, 8'h5A, 0, 0, 0);
    set_vec(2,  "burst_wr",     6, 8'hEE, 8'h0E, 8'h03, 8'h11, 8'h22, 8'h33, 0, 0, 0, 0, 0);
    set_vec(3,  "burst_rd",     3, 8'hEF, 8'h0E, 8'h03, 0, 0, 0,          3, 8'h11, 8'h22, 8'h33, 0);
    set_vec(4,  "alu_add",      4, 8'hCC, 8'h05, 8'h03, 8'h00, 0, 0,      2, 8'h08, 8'h00, 0, 0);
    set_vec(5,  "bad_op",       1, 8'h12, 0, 0, 0, 0, 0,                  1, 8'hFF, 0, 0, 0);
    set_vec(6,  "wr_hi_addr",   3, 8'hAA, 8'h13, 8'hC3, 0, 0, 0,          0, 0, 0, 0, 0);
    set_vec(7,  "rd_after_err", 2, 8'hBB, 8'h03, 0, 0, 0, 0,              1, 8'hC3, 0, 0, 0);
    set_vec(8,  "alu_mul",      4, 8'hCC, 8'hF0, 8'h10, 8'h02, 0, 0,      2, 8'h00, 8'h0F, 0, 0);
    set_vec(9,  "alu_only_sub", 2, 8'hDD, 8'h01, 0, 0, 0, 0,              2, 8'hE0, 8'h00, 0, 0);
    set_vec(10, "burst_wr_n0",  3, 8'hEE, 8'h05, 8'h00, 0, 0, 0,          0, 0, 0, 0, 0);
    set_vec(11, "rd5",          2, 8'hBB, 8'h05, 0, 0, 0, 0,              1, 8'h55, 0, 0, 0);
    set_vec(12, "burst_rd_n0",  3, 8'hEF, 8'h00, 8'h00, 0, 0, 0,          0, 0, 0, 0, 0);

    // Reset
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_addr", rf_addr, 0);
    check("rst_we", rf_we, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_re", rf_re, 0);
    check("rst_alu_func", alu_func, 0);
    check("rst_alu_en", alu_en, 0);
    check("rst_alu_clk_en", alu_clk_en, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_overrun", overrun, 0);

    // Frame vector table
    for (int v = 0; v < 13; v++) begin
      for (int k = 0; k < vecs[v].n_in; k++) send_byte(vecs[v].in_b[k]);
      for (int k = 0; k < vecs[v].n_exp; k++) exp_q.push_back(vecs[v].exp_b[k]);
      wait_resp(vecs[v].name);
    end
    check("mem14", rf_mem[14], 8'h11);
    check("mem15", rf_mem[15], 8'h22);
    check("mem0", rf_mem[0], 8'hF0);
    check("mem1", rf_mem[1], 8'h10);
    check("mem3", rf_mem[3], 8'hC3);
    check("mem5", rf_mem[5], 8'h55);

    // Write strobe lands the cycle after the data byte, read strobe after the addr byte
    send_byte(8'hAA);
    send_byte(8'h07);
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h9C;
    @(negedge clk); rx_valid = 1'b0;
    check("wr_strobe", rf_we, 1);
    check("wr_strobe_addr", rf_addr, 7);
    check("wr_strobe_data", rf_wdata, 8'h9C);
    @(negedge clk);
    check("wr_strobe_single", rf_we, 0);
    repeat (2) @(negedge clk);
    send_byte(8'hBB);
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h07;
    @(negedge clk); rx_valid = 1'b0;
    check("rd_strobe", rf_re, 1);
    check("rd_strobe_addr", rf_addr, 7);
    @(negedge clk);
    check("rd_strobe_single", rf_re, 0);
    check("rd_tx_not_yet", tx_valid, 0);
    @(negedge clk);
    check("rd_tx_valid", tx_valid, 1);
    check("rd_tx_data", tx_data, 8'h9C);
    exp_q.push_back(8'h9C);
    wait_resp("rd_timing");

    // Timeout after an opcode with no further bytes
    rd_cnt = 0;
    send_byte(8'hBB);
    lat = 0;
    while (!tx_valid && lat < T_CYC + 100) begin
      @(negedge clk);
      lat++;
    end
    check("timeout_latency_ok", (lat >= T_CYC - 8 && lat <= T_CYC + 8), 1);
    exp_q.push_back(8'hFF);
    wait_resp("timeout");
    check("timeout_no_read", rd_cnt, 0);
    send_byte(8'hBB);
    send_byte(8'h07);
    exp_q.push_back(8'h9C);
    wait_resp("after_timeout");

    // Back-pressure: 10-byte burst read into an 8-deep queue
    for (int k = 0; k < 12; k++)
      send_byte(k == 0 ? 8'hEE : k == 1 ? 8'h00 : k == 2 ? 8'h0A : 8'hA0 + 8'(k - 3));
    send_byte(8'hA9);
    wait_resp("stall_prefill");
    @(negedge clk);
    tx_ready = 1'b0;
    rd_cnt = 0;
    ov_cnt = 0;
    send_byte(8'hEF);
    send_byte(8'h00);
    send_byte(8'h0A);
    repeat (60) @(negedge clk);
    check("stall_reads", rd_cnt, 8);
    check("stall_valid", tx_valid, 1);
    check("stall_head", tx_data, 8'hA0);
    send_byte(8'h12);
    repeat (3) @(negedge clk);
    check("stall_overrun", ov_cnt, 1);
    check("stall_head_stable", tx_data, 8'hA0);
    tx_ready = 1'b1;
    for (int k = 0; k < 10; k++) exp_q.push_back(8'hA0 + 8'(k));
    wait_resp("stall_drain");

    // Reset mid-frame drops the queue and the partial frame
    tx_ready = 1'b0;
    send_byte(8'hBB);
    send_byte(8'h03);
    repeat (6) @(negedge clk);
    check("pre_reset_queued", tx_valid, 1);
    send_byte(8'hEE);
    send_byte(8'h02);
    send_byte(8'h02);
    send_byte(8'h11);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_tx_valid", tx_valid, 0);
    check("mid_reset_tx_data", tx_data, 0);
    tx_ready = 1'b1;
    got_q.delete();
    send_byte(8'hAA);
    send_byte(8'h04);
    send_byte(8'h77);
    send_byte(8'hBB);
    send_byte(8'h04);
    exp_q.push_back(8'h77);
    wait_resp("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
